// File: rtl/fetch_unit.sv
// fetch_unit: PC-driven wait-stated instruction fetch with a small decode buffer and redirect flush.
module fetch_unit #(
  parameter logic [15:0] RESET_PC   = 16'h0000,
  parameter int          FIFO_DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst,
  output logic [15:0] bus_addr_o,
  output logic        bus_re_o,
  input  logic        bus_needWait_i,
  input  logic [15:0] bus_data_i,
  output logic [15:0] instr_o,
  output logic [15:0] instr_pc_o,
  output logic        instr_valid_o,
  input  logic        instr_ready_i,
  input  logic        redirect_i,
  input  logic [15:0] redirect_addr_i
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [AW:0] FULL = (AW+1)'(FIFO_DEPTH);
  typedef enum logic [1:0] {IDLE, REQ, GAP} state_t;
  state_t        state_q, state_d;
  logic [15:0]   pc_q, pc_d;
  logic [15:0]   data_q [FIFO_DEPTH];
  logic [15:0]   data_d [FIFO_DEPTH];
  logic [15:0]   ipc_q [FIFO_DEPTH];
  logic [15:0]   ipc_d [FIFO_DEPTH];
  logic [AW-1:0] rd_q, rd_d, wr_q, wr_d;
  logic [AW:0]   count_q, count_d;
  logic          push, pop;
  assign bus_addr_o    = pc_q;
  assign bus_re_o      = state_q == REQ;
  assign instr_valid_o = count_q != '0;
  assign instr_o       = instr_valid_o ? data_q[rd_q] : '0;
  assign instr_pc_o    = instr_valid_o ? ipc_q[rd_q] : '0;
  // a redirect abandons both the completing read and any pop in the same cycle
  always_comb begin
    push = state_q == REQ && !bus_needWait_i && !redirect_i;
    pop = instr_valid_o && instr_ready_i && !redirect_i;
    data_d = data_q;
    ipc_d = ipc_q;
    if (push) begin
      data_d[wr_q] = bus_data_i;
      ipc_d[wr_q] = pc_q;
    end
    wr_d = redirect_i ? '0 : wr_q + AW'(push);
    rd_d = redirect_i ? '0 : rd_q + AW'(pop);
    count_d = redirect_i ? '0 : count_q + (AW+1)'(push) - (AW+1)'(pop);
    pc_d = redirect_i ? redirect_addr_i & 16'hFFFE : push ? pc_q + 16'd2 : pc_q;
    state_d = state_q;
    case (state_q)
      IDLE:    state_d = count_q < FULL ? REQ : IDLE;
      REQ:     state_d = bus_needWait_i ? REQ : GAP;
      GAP:     state_d = count_d < FULL ? REQ : IDLE;
      default: state_d = IDLE;
    endcase
    if (redirect_i) state_d = GAP;
  end
  always_ff @(posedge clk) begin
    data_q <= data_d;
    ipc_q <= ipc_d;
    if (rst) begin
      state_q <= IDLE;
      pc_q <= RESET_PC & 16'hFFFE;
      rd_q <= '0;
      wr_q <= '0;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      pc_q <= pc_d;
      rd_q <= rd_d;
      wr_q <= wr_d;
      count_q <= count_d;
    end
  end
endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: random and directed stimulus checked against a queue-based fetch reference model.
module tb_fetch_unit;
  localparam int DEPTH = 2;
  logic clk = 0, rst, bus_re_o, bus_needWait_i, instr_valid_o, instr_ready_i, redirect_i;
  logic [15:0] bus_addr_o, bus_data_i, instr_o, instr_pc_o, redirect_addr_i;
  int total = 0, bad = 0, wcnt = 0, wait_n = 1, n;
  bit rand_wait = 0;
  logic [15:0] mpc, a;
  logic m_re, m_gap;
  logic [15:0] q[$];

  fetch_unit #(.RESET_PC(16'h0000), .FIFO_DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .bus_addr_o(bus_addr_o), .bus_re_o(bus_re_o),
    .bus_needWait_i(bus_needWait_i), .bus_data_i(bus_data_i), .instr_o(instr_o),
    .instr_pc_o(instr_pc_o), .instr_valid_o(instr_valid_o), .instr_ready_i(instr_ready_i),
    .redirect_i(redirect_i), .redirect_addr_i(redirect_addr_i));

  always #5 clk = ~clk;

  function automatic logic [15:0] word(input logic [15:0] ad);
    return ad == 16'h0000 ? 16'h0bb6 : ad == 16'h0002 ? 16'h0102 : {ad[7:0], ad[15:8]} ^ 16'hA55A;
  endfunction

  task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // reference: each fetch is a run of request cycles ending in one data beat, then a mandatory idle beat
  task automatic model_edge();
    logic done;
    int pre;
    if (rst) begin
      mpc = 16'h0000; q.delete(); m_re = 0; m_gap = 0;
    end else if (redirect_i) begin
      mpc = redirect_addr_i & 16'hFFFE; q.delete(); m_re = 0; m_gap = 1;
    end else begin
      pre = q.size();
      done = m_re && !bus_needWait_i;
      if (pre != 0 && instr_ready_i) void'(q.pop_front());
      if (done) begin q.push_back(mpc); mpc += 16'd2; end
      if (m_re) begin m_re = !done; m_gap = done; end
      else if (m_gap) begin m_gap = 0; m_re = q.size() < DEPTH; end
      else m_re = pre < DEPTH;
    end
  endtask

  task automatic drive_mem();
    if (bus_re_o) begin
      wcnt++;
      if (wcnt == 1 && rand_wait) wait_n = $urandom_range(0, 3);
    end else wcnt = 0;
    bus_needWait_i = bus_re_o && (wcnt <= wait_n);
    bus_data_i = (bus_needWait_i || !bus_re_o) ? 16'($urandom) : word(bus_addr_o);
  endtask

  task automatic check_model();
    chk("re", {15'b0, bus_re_o}, {15'b0, m_re});
    chk("addr", bus_addr_o, mpc);
    chk("valid", {15'b0, instr_valid_o}, {15'b0, q.size() != 0});
    if (q.size() != 0) begin
      chk("instr", instr_o, word(q[0]));
      chk("ipc", instr_pc_o, q[0]);
    end
  endtask

  task automatic tick();
    model_edge();
    @(posedge clk);
    #1;
    drive_mem();
    check_model();
  endtask

  task automatic do_reset();
    rst = 1; tick(); rst = 0;
  endtask

  task automatic wait_valid(input int max);
    int k = 0;
    while (!instr_valid_o && k < max) begin tick(); k++; end
    chk("wait_valid", {15'b0, instr_valid_o}, 16'd1);
  endtask

  task automatic wait_re(input int max);
    int k = 0;
    while (!bus_re_o && k < max) begin tick(); k++; end
    chk("wait_re", {15'b0, bus_re_o}, 16'd1);
  endtask

  initial begin
    rst = 1; instr_ready_i = 1; redirect_i = 0; redirect_addr_i = 0;
    bus_needWait_i = 0; bus_data_i = 0;
    tick(); do_reset();
    chk("rst_re", {15'b0, bus_re_o}, 16'd0);
    chk("rst_valid", {15'b0, instr_valid_o}, 16'd0);
    chk("rst_instr", instr_o, 16'h0000);
    chk("rst_ipc", instr_pc_o, 16'h0000);
    chk("rst_addr", bus_addr_o, 16'h0000);
    // basic fetch timing: REQ, REQ, GAP
    tick(); chk("c1_re", {15'b0, bus_re_o}, 16'd1);
    tick(); chk("c2_re", {15'b0, bus_re_o}, 16'd1);
    tick(); chk("c3_re", {15'b0, bus_re_o}, 16'd0);
    chk("c3_valid", {15'b0, instr_valid_o}, 16'd1);
    chk("c3_instr", instr_o, 16'h0bb6);
    chk("c3_ipc", instr_pc_o, 16'h0000);
    tick(); tick(); tick();
    chk("c6_instr", instr_o, 16'h0102);
    chk("c6_ipc", instr_pc_o, 16'h0002);
    // decode stalled: buffer fills and the bus parks
    instr_ready_i = 0; do_reset();
    repeat (20) tick();
    chk("full_re", {15'b0, bus_re_o}, 16'd0);
    chk("full_instr", instr_o, 16'h0bb6);
    instr_ready_i = 1; tick(); instr_ready_i = 0;
    chk("pop_instr", instr_o, 16'h0102);
    tick();
    chk("refill_re", {15'b0, bus_re_o}, 16'd1);
    chk("refill_addr", bus_addr_o, 16'h0004);
    // redirect on the completing request cycle
    do_reset(); tick();
    n = 0;
    while (!(bus_re_o && !bus_needWait_i) && n < 10) begin tick(); n++; end
    redirect_i = 1; redirect_addr_i = 16'h0101; tick(); redirect_i = 0;
    chk("rd_valid", {15'b0, instr_valid_o}, 16'd0);
    chk("rd_re", {15'b0, bus_re_o}, 16'd0);
    chk("rd_addr", bus_addr_o, 16'h0100);
    wait_valid(10);
    chk("rd_ipc", instr_pc_o, 16'h0100);
    // PC wrap
    redirect_i = 1; redirect_addr_i = 16'hFFFE; tick(); redirect_i = 0;
    wait_valid(10);
    chk("wrap_ipc0", instr_pc_o, 16'hFFFE);
    instr_ready_i = 1; tick(); instr_ready_i = 0;
    wait_valid(10);
    chk("wrap_ipc1", instr_pc_o, 16'h0000);
    // reset with a read outstanding and one buffered entry
    do_reset(); wait_valid(10); wait_re(10);
    chk("mid_cnt", {15'b0, instr_valid_o}, 16'd1);
    rst = 1; tick(); rst = 0;
    chk("mid_re", {15'b0, bus_re_o}, 16'd0);
    chk("mid_valid", {15'b0, instr_valid_o}, 16'd0);
    wait_re(5);
    chk("mid_addr", bus_addr_o, 16'h0000);
    // long stall
    do_reset(); wait_n = 5; wait_re(5);
    a = bus_addr_o; n = 0;
    while (bus_re_o && n < 20) begin chk("stall_addr", bus_addr_o, a); n++; tick(); end
    chk("stall_len", 16'(n), 16'd6);
    wait_valid(5);
    chk("stall_instr", instr_o, word(a));
    // randomized traffic
    rand_wait = 1;
    for (int i = 0; i < 600; i++) begin
      instr_ready_i = ($urandom % 3) != 0;
      redirect_i = ($urandom % 25) == 0;
      redirect_addr_i = 16'($urandom);
      rst = ($urandom % 97) == 0;
      tick();
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
